// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry stall hold buffer,
// redirect flush and sticky halt.
//
// state   | meaning
// --------+-----------------------------------------------
// S_REQ   | idle, may issue a fetch request
// S_WAIT  | one request outstanding, response expected
// S_DROP  | outstanding response belongs to a flushed path
// S_HALTED| stopped until reset
module fetch_stage #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_sys,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [3:0]         opcode,
  output logic [3:0]         func,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HALTED
  } state_t;

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    req_pc;
  logic               hold_valid;
  logic [INSTR_W-1:0] hold_instr;
  logic [PC_W-1:0]    hold_pc;

  logic resp;
  logic halting;
  logic issue;

  assign resp    = (state == S_WAIT) && imem.imem_valid;
  assign halting = halt_sys && if_valid;
  // Issuing in the same cycle a response lands keeps 1 instr/cycle at 1-cycle latency.
  assign issue   = !rst && ((state == S_REQ) || resp) && !stall && !hold_valid
                   && !redirect && !halting;

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc;

  assign opcode = if_instr[INSTR_W-1 -: 4];
  assign func   = if_instr[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      req_pc     <= '0;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
      halted     <= 1'b0;
    end else if (state != S_HALTED) begin
      if (halting) begin
        state      <= S_HALTED;
        halted     <= 1'b1;
        if_valid   <= 1'b0;
        hold_valid <= 1'b0;
      end else if (redirect) begin
        if_valid   <= 1'b0;
        hold_valid <= 1'b0;
        pc         <= redirect_pc;
        // A request still in flight must have its stale response swallowed.
        if (((state == S_WAIT) || (state == S_DROP)) && !imem.imem_valid)
          state <= S_DROP;
        else
          state <= S_REQ;
      end else begin
        if (issue) begin
          pc     <= pc + PC_W'(2);
          req_pc <= pc;
        end

        if (!stall) begin
          if (hold_valid) begin
            if_valid   <= 1'b1;
            if_instr   <= hold_instr;
            if_pc      <= hold_pc;
            hold_valid <= 1'b0;
          end else if (resp) begin
            if_valid <= 1'b1;
            if_instr <= imem.imem_rdata;
            if_pc    <= req_pc;
          end else begin
            if_valid <= 1'b0;
          end
        end else if (resp) begin
          hold_valid <= 1'b1;
          hold_instr <= imem.imem_rdata;
          hold_pc    <= req_pc;
        end

        case (state)
          S_REQ:   if (issue) state <= S_WAIT;
          S_WAIT:  if (resp) state <= issue ? S_WAIT : S_REQ;
          S_DROP:  if (imem.imem_valid) state <= S_REQ;
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected fetch
// addresses and IF/ID contents; a negedge monitor pops and compares.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt_sys = 1'b0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [3:0]  opcode;
  logic [3:0]  func;
  logic        halted;

  fetch_stage_if #(.PC_W(16), .INSTR_W(16)) bus ();

  fetch_stage #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_sys    (halt_sys),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .opcode      (opcode),
    .func        (func),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] exp_addr[$];
  logic [31:0] exp_if[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got %h expected nothing (t=%0t)", name, act, $time);
  endtask

  // memory model: fixed latency, limited number of answered requests
  int          lat = 1;
  int          budget = 0;
  logic        ovr_en = 1'b0;
  logic [15:0] ovr_addr = 16'h0000;
  logic [15:0] ovr_data = 16'h0000;
  logic        spur = 1'b0;
  logic        req_seen = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_addr = 16'h0000;

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    if (ovr_en && (a == ovr_addr)) return ovr_data;
    return {4'h1, a[11:0]};
  endfunction

  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      bus.imem_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (req_seen) begin
          pend      = 1'b1;
          pend_cnt  = lat;
          pend_addr = req_addr;
        end
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            pend = 1'b0;
            if (budget > 0) begin
              budget--;
              bus.imem_valid = 1'b1;
              bus.imem_rdata = mem_data(pend_addr);
            end
          end
        end
        if (spur) begin
          bus.imem_valid = 1'b1;
          bus.imem_rdata = 16'hDEAD;
        end
      end
    end
  end

  logic        stall_q = 1'b0;
  logic [15:0] ea;
  logic [31:0] ei;

  always @(posedge clk) stall_q <= stall;

  always @(negedge clk) begin
    req_seen = bus.imem_req && !rst;
    req_addr = bus.imem_addr;
    if (!rst) begin
      if (bus.imem_req) begin
        if (exp_addr.size() == 0) unexpected("fetch_addr", {16'h0, bus.imem_addr});
        else begin
          ea = exp_addr.pop_front();
          check("fetch_addr", {16'h0, bus.imem_addr}, {16'h0, ea});
        end
      end
      // a fresh IF/ID entry appears only after a non-stalled edge
      if (if_valid && !stall_q) begin
        if (exp_if.size() == 0) unexpected("if_entry", {if_instr, if_pc});
        else begin
          ei = exp_if.pop_front();
          check("if_instr", {16'h0, if_instr}, {16'h0, ei[31:16]});
          check("if_pc", {16'h0, if_pc}, {16'h0, ei[15:0]});
          check("opcode", {28'h0, opcode}, {28'h0, ei[31:28]});
          check("func", {28'h0, func}, {28'h0, ei[19:16]});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scn(input int l, input int b);
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    halt_sys = 1'b0;
    spur = 1'b0;
    ovr_en = 1'b0;
    cyc();
    lat = l;
    budget = b;
    exp_addr.delete();
    exp_if.delete();
    @(negedge clk);
    check("rst_imem_req", {31'h0, bus.imem_req}, 32'h0);
    check("rst_if_valid", {31'h0, if_valid}, 32'h0);
    check("rst_if_instr", {16'h0, if_instr}, 32'h0);
    check("rst_if_pc", {16'h0, if_pc}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_opcode_func", {24'h0, opcode, func}, 32'h0);
    cyc();
  endtask

  task automatic end_scn(input string name);
    repeat (8) cyc();
    check({name, "_fetch_q_drained"}, exp_addr.size(), 32'h0);
    check({name, "_if_q_drained"}, exp_if.size(), 32'h0);
  endtask

  initial begin
    // 1: streaming at 1-cycle latency
    start_scn(1, 3);
    exp_addr = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
    exp_if   = '{{16'h1000, 16'h0000}, {16'h1002, 16'h0002}, {16'h1004, 16'h0004}};
    rst = 1'b0;
    @(negedge clk);
    check("s1_first_req", {31'h0, bus.imem_req}, 32'h1);
    cyc();
    @(negedge clk);
    check("s1_if_valid_c1", {31'h0, if_valid}, 32'h0);
    cyc();
    @(negedge clk);
    check("s1_if_valid_c2", {31'h0, if_valid}, 32'h1);
    end_scn("s1");

    // 2: stall while a response lands in the hold buffer
    start_scn(1, 2);
    ovr_en = 1'b1; ovr_addr = 16'h0002; ovr_data = 16'h2345;
    exp_addr = '{16'h0000, 16'h0002, 16'h0004};
    exp_if   = '{{16'h1000, 16'h0000}, {16'h2345, 16'h0002}};
    rst = 1'b0;
    cyc();
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge clk);
      check("s2_stall_if_instr", {16'h0, if_instr}, 32'h1000);
      check("s2_stall_no_req", {31'h0, bus.imem_req}, 32'h0);
    end
    cyc();
    stall = 1'b0;
    @(negedge clk);
    check("s2_hold_full_no_req", {31'h0, bus.imem_req}, 32'h0);
    check("s2_if_instr_c5", {16'h0, if_instr}, 32'h1000);
    cyc();
    @(negedge clk);
    check("s2_hold_released", {16'h0, if_instr}, 32'h2345);
    check("s2_func", {28'h0, func}, 32'h5);
    end_scn("s2");

    // 3: redirect with a 3-cycle-latency response outstanding
    start_scn(3, 2);
    exp_addr = '{16'h0000, 16'h0040, 16'h0042};
    exp_if   = '{{16'h1040, 16'h0040}};
    rst = 1'b0;
    cyc();
    redirect = 1'b1; redirect_pc = 16'h0040;
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    check("s3_flush_if_valid", {31'h0, if_valid}, 32'h0);
    check("s3_drop_no_req_c2", {31'h0, bus.imem_req}, 32'h0);
    cyc();
    @(negedge clk);
    check("s3_drop_no_req_c3", {31'h0, bus.imem_req}, 32'h0);
    check("s3_stale_resp_present", {31'h0, bus.imem_valid}, 32'h1);
    cyc();
    @(negedge clk);
    check("s3_refetch_req", {31'h0, bus.imem_req}, 32'h1);
    check("s3_refetch_addr", {16'h0, bus.imem_addr}, 32'h0040);
    end_scn("s3");

    // 4: redirect together with stall while the hold buffer is full
    start_scn(1, 3);
    exp_addr = '{16'h0000, 16'h0002, 16'h0080, 16'h0082};
    exp_if   = '{{16'h1000, 16'h0000}, {16'h1080, 16'h0080}};
    rst = 1'b0;
    cyc();
    cyc();
    stall = 1'b1;
    cyc();
    redirect = 1'b1; redirect_pc = 16'h0080;
    cyc();
    stall = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    check("s4_flush_if_valid", {31'h0, if_valid}, 32'h0);
    check("s4_fetch_redirect_addr", {16'h0, bus.imem_addr}, 32'h0080);
    cyc();
    @(negedge clk);
    check("s4_hold_discarded", {31'h0, if_valid}, 32'h0);
    end_scn("s4");

    // 5: halt beats redirect, then spurious responses, then reset recovery
    start_scn(1, 2);
    ovr_en = 1'b1; ovr_addr = 16'h0000; ovr_data = 16'hF000;
    exp_addr = '{16'h0000, 16'h0002};
    exp_if   = '{{16'hF000, 16'h0000}};
    rst = 1'b0;
    cyc();
    cyc();
    halt_sys = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0080;
    cyc();
    halt_sys = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    check("s5_halted", {31'h0, halted}, 32'h1);
    check("s5_if_valid", {31'h0, if_valid}, 32'h0);
    for (int i = 0; i < 22; i++) begin
      cyc();
      spur = (i % 3 == 0);
      @(negedge clk);
      check("s5_halted_no_req", {31'h0, bus.imem_req}, 32'h0);
    end
    cyc();
    spur = 1'b0;
    @(negedge clk);
    check("s5_still_halted", {31'h0, halted}, 32'h1);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("s5_rst_clears_halted", {31'h0, halted}, 32'h0);
    cyc();
    exp_addr = '{16'h0000};
    rst = 1'b0;
    @(negedge clk);
    check("s5_restart_addr", {16'h0, bus.imem_addr}, 32'h0000);
    check("s5_restart_req", {31'h0, bus.imem_req}, 32'h1);
    end_scn("s5");

    // 6: PC wrap from 0xFFFE
    start_scn(1, 2);
    exp_addr = '{16'hFFFE, 16'h0000, 16'h0002};
    exp_if   = '{{16'h1FFE, 16'hFFFE}, {16'h1000, 16'h0000}};
    rst = 1'b0;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    @(negedge clk);
    check("s6_redirect_blocks_req", {31'h0, bus.imem_req}, 32'h0);
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    check("s6_addr_fffe", {16'h0, bus.imem_addr}, 32'hFFFE);
    cyc();
    @(negedge clk);
    check("s6_addr_wrap", {16'h0, bus.imem_addr}, 32'h0000);
    end_scn("s6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
